// File: rtl/pcie_tx_ab_arb_commit.sv
// pcie_tx_ab_arb_commit: merges AFU TX A (all TLPs) and TX B (reads/interrupts)
// into one packet-atomic round-robin stream behind a single output register,
// and returns a local write-commit completion on RX B for every A memory write
// once its last beat leaves the output register.
// Optional statistics counters: define PCIE_TX_AB_ARB_STATS_EN.
module pcie_tx_ab_arb_commit #(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned USER_W       = 10,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_tvalid,
  output logic                a_tready,
  input  logic [DATA_W-1:0]   a_tdata,
  input  logic [DATA_W/8-1:0] a_tkeep,
  input  logic                a_tlast,
  input  logic [USER_W-1:0]   a_tuser,
  input  logic                b_tvalid,
  output logic                b_tready,
  input  logic [DATA_W-1:0]   b_tdata,
  input  logic [DATA_W/8-1:0] b_tkeep,
  input  logic                b_tlast,
  input  logic [USER_W-1:0]   b_tuser,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [DATA_W-1:0]   o_tdata,
  output logic [DATA_W/8-1:0] o_tkeep,
  output logic                o_tlast,
  output logic [USER_W-1:0]   o_tuser,
  output logic                c_tvalid,
  input  logic                c_tready,
  output logic [DATA_W-1:0]   c_tdata,
  output logic [DATA_W/8-1:0] c_tkeep,
  output logic                c_tlast,
  output logic [USER_W-1:0]   c_tuser
`ifdef PCIE_TX_AB_ARB_STATS_EN
  ,
  output logic [31:0]         stat_a_pkts,
  output logic [31:0]         stat_b_pkts,
  output logic [31:0]         stat_commits,
  output logic [31:0]         stat_a_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(COMMIT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t           state, state_nxt;
  logic             rr_b, rr_b_nxt;     // 1: B wins the next contended SOP
  logic             load, commit_space, a_ok;
  logic             grant_a, grant_b, a_acc, b_acc;
  logic [7:0]       a_fmt;
  logic             a_is_wr, pend_wr, beat_wr;
  logic [9:0]       a_tag, pend_tag, beat_tag;
  logic             o_src_a, o_is_wr;
  logic [9:0]       o_tag;
  logic             push, pop, rsv_inc;
  logic [9:0]       fifo_mem [COMMIT_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] fcnt, resv;

  assign load         = !o_tvalid || o_tready;
  // resv counts writes from SOP grant until commit pop, so the FIFO never overflows
  assign commit_space = resv < CNT_W'(COMMIT_DEPTH);
  assign a_ok         = a_tvalid && commit_space;
  assign a_fmt        = a_tdata[31:24];
  assign a_is_wr      = a_fmt[6] && (a_fmt[4:0] == 5'd0);
  assign a_tag        = {a_tdata[23], a_tdata[19], a_tdata[47:40]};
  assign beat_wr      = (state == IDLE) ? a_is_wr : pend_wr;
  assign beat_tag     = (state == IDLE) ? a_tag   : pend_tag;
  assign a_tready     = load && grant_a;
  assign b_tready     = load && grant_b;
  assign a_acc        = a_tready;
  assign b_acc        = b_tready;
  assign rsv_inc      = a_acc && (state == IDLE) && a_is_wr;
  assign push         = o_tvalid && o_tready && o_tlast && o_src_a && o_is_wr;
  assign c_tvalid     = (fcnt != '0);
  assign pop          = c_tvalid && c_tready;
  assign c_tlast      = 1'b1;
  assign c_tuser      = '0;

  // Grant selection and packet-lock state transitions
  always_comb begin
    state_nxt = state;
    rr_b_nxt  = rr_b;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (a_ok && (!b_tvalid || !rr_b)) grant_a = 1'b1;
        else if (b_tvalid)                grant_b = 1'b1;
      end
      LOCK_A:  grant_a = a_tvalid;
      LOCK_B:  grant_b = b_tvalid;
      default: state_nxt = IDLE;
    endcase
    if (a_acc) begin
      if (a_tlast) begin
        state_nxt = IDLE;
        rr_b_nxt  = 1'b1;
      end else begin
        state_nxt = LOCK_A;
      end
    end else if (b_acc) begin
      if (b_tlast) begin
        state_nxt = IDLE;
        rr_b_nxt  = 1'b0;
      end else begin
        state_nxt = LOCK_B;
      end
    end
  end

  // FSM state and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_b  <= 1'b0;
    end else begin
      state <= state_nxt;
      rr_b  <= rr_b_nxt;
    end
  end

  // Hold write flag/tag of a multi-beat A packet until its last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr  <= 1'b0;
      pend_tag <= '0;
    end else if (a_acc && (state == IDLE)) begin
      pend_wr  <= a_is_wr;
      pend_tag <= a_tag;
    end
  end

  // Merged output register with source/write sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tkeep  <= '0;
      o_tlast  <= 1'b0;
      o_tuser  <= '0;
      o_src_a  <= 1'b0;
      o_is_wr  <= 1'b0;
      o_tag    <= '0;
    end else if (load) begin
      o_tvalid <= a_acc || b_acc;
      if (a_acc) begin
        o_tdata <= a_tdata;
        o_tkeep <= a_tkeep;
        o_tlast <= a_tlast;
        o_tuser <= a_tuser;
        o_src_a <= 1'b1;
        o_is_wr <= beat_wr;
        o_tag   <= beat_tag;
      end else if (b_acc) begin
        o_tdata <= b_tdata;
        o_tkeep <= b_tkeep;
        o_tlast <= b_tlast;
        o_tuser <= b_tuser;
        o_src_a <= 1'b0;
        o_is_wr <= 1'b0;
        o_tag   <= '0;
      end
    end
  end

  // Commit FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= o_tag;
  end

  // Commit FIFO pointers, occupancy and reservation count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      resv <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + CNT_W'(1);
        2'b01:   fcnt <= fcnt - CNT_W'(1);
        default: fcnt <= fcnt;
      endcase
      case ({rsv_inc, pop})
        2'b10:   resv <= resv + CNT_W'(1);
        2'b01:   resv <= resv - CNT_W'(1);
        default: resv <= resv;
      endcase
    end
  end

  // Header-only completion built from the FIFO head
  always_comb begin
    c_tdata = '0;
    c_tkeep = '0;
    if (c_tvalid) begin
      c_tdata[31:24] = 8'h0A;
      c_tdata[23]    = fifo_mem[rptr][9];
      c_tdata[19]    = fifo_mem[rptr][8];
      c_tdata[47:40] = fifo_mem[rptr][7:0];
      c_tkeep[31:0]  = '1;
    end
  end

`ifdef PCIE_TX_AB_ARB_STATS_EN
  // Wrapping event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_a_pkts  <= '0;
      stat_b_pkts  <= '0;
      stat_commits <= '0;
      stat_a_stall <= '0;
    end else begin
      if (a_acc && a_tlast)         stat_a_pkts  <= stat_a_pkts + 32'd1;
      if (b_acc && b_tlast)         stat_b_pkts  <= stat_b_pkts + 32'd1;
      if (pop)                      stat_commits <= stat_commits + 32'd1;
      if (a_tvalid && !a_tready)    stat_a_stall <= stat_a_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_tx_ab_arb_commit.sv
// Directed self-checking bench for pcie_tx_ab_arb_commit.
module tb_pcie_tx_ab_arb_commit;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_tvalid, a_tready, a_tlast;
  logic [511:0] a_tdata;
  logic [63:0]  a_tkeep;
  logic [9:0]   a_tuser;
  logic         b_tvalid, b_tready, b_tlast;
  logic [511:0] b_tdata;
  logic [63:0]  b_tkeep;
  logic [9:0]   b_tuser;
  logic         o_tvalid, o_tready, o_tlast;
  logic [511:0] o_tdata;
  logic [63:0]  o_tkeep;
  logic [9:0]   o_tuser;
  logic         c_tvalid, c_tready, c_tlast;
  logic [511:0] c_tdata;
  logic [63:0]  c_tkeep;
  logic [9:0]   c_tuser;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  pcie_tx_ab_arb_commit #(.DATA_W(512), .USER_W(10), .COMMIT_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tdata(a_tdata), .a_tkeep(a_tkeep),
    .a_tlast(a_tlast), .a_tuser(a_tuser),
    .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata), .b_tkeep(b_tkeep),
    .b_tlast(b_tlast), .b_tuser(b_tuser),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata), .o_tkeep(o_tkeep),
    .o_tlast(o_tlast), .o_tuser(o_tuser),
    .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tdata(c_tdata), .c_tkeep(c_tkeep),
    .c_tlast(c_tlast), .c_tuser(c_tuser)
  );

  // TLP header: fmt_type, 10-bit tag, and a bench-only id in the top word
  function automatic logic [511:0] mk_hdr(input logic [7:0] fmt, input logic [9:0] tag,
                                          input logic [31:0] id);
    logic [511:0] d;
    d = '0;
    d[31:24]   = fmt;
    d[23]      = tag[9];
    d[19]      = tag[8];
    d[47:40]   = tag[7:0];
    d[511:480] = id;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tdata = '0; a_tkeep = '1; a_tuser = '0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0; b_tkeep = '1; b_tuser = '0;
    o_tready = 1'b0; c_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL reset_o_tvalid got %b want 0", o_tvalid); end
    tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL reset_c_tvalid got %b want 0", c_tvalid); end
    tests_run++; if (o_tdata !== '0) begin fails++; $display("FAIL reset_o_tdata got %h want 0", o_tdata); end
    tests_run++; if (c_tdata !== '0) begin fails++; $display("FAIL reset_c_tdata got %h want 0", c_tdata); end
    tests_run++; if (a_tready !== 1'b0 || b_tready !== 1'b0) begin fails++; $display("FAIL reset_ready got a=%b b=%b want 0 0", a_tready, b_tready); end
  endtask

  task automatic test_single_write();
    logic [511:0] d;
    do_reset();
    o_tready = 1'b1; c_tready = 1'b1;
    d = mk_hdr(8'h60, 10'h2A5, 32'h0000_00A1);
    @(negedge clk);
    a_tvalid = 1'b1; a_tdata = d; a_tlast = 1'b1; a_tuser = 10'h003;
    #1;
    tests_run++; if (a_tready !== 1'b1) begin fails++; $display("FAIL wr_a_tready got %b want 1", a_tready); end
    @(negedge clk);
    a_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tvalid !== 1'b1 || o_tdata !== d) begin fails++; $display("FAIL wr_out got v=%b d=%h want v=1 d=%h", o_tvalid, o_tdata, d); end
    tests_run++; if (o_tlast !== 1'b1 || o_tuser !== 10'h003 || o_tkeep !== '1) begin fails++; $display("FAIL wr_side got last=%b user=%h keep=%h want 1 003 all-ones", o_tlast, o_tuser, o_tkeep); end
    tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL wr_c_early got %b want 0", c_tvalid); end
    @(negedge clk);
    #1;
    tests_run++; if (c_tvalid !== 1'b1 || c_tdata !== mk_hdr(8'h0A, 10'h2A5, 32'h0)) begin fails++; $display("FAIL wr_commit got v=%b d=%h want v=1 d=%h", c_tvalid, c_tdata, mk_hdr(8'h0A, 10'h2A5, 32'h0)); end
    tests_run++; if (c_tkeep !== 64'h0000_0000_FFFF_FFFF || c_tlast !== 1'b1 || c_tuser !== 10'h0) begin fails++; $display("FAIL wr_commit_side got keep=%h last=%b user=%h want 00000000ffffffff 1 000", c_tkeep, c_tlast, c_tuser); end
    tests_run++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL wr_o_drop got %b want 0", o_tvalid); end
    @(negedge clk);
    #1;
    tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL wr_c_pop got %b want 0", c_tvalid); end
  endtask

  task automatic test_alternate();
    int na, nb;
    do_reset();
    o_tready = 1'b1; c_tready = 1'b1;
    na = 0; nb = 0;
    @(negedge clk);
    a_tvalid = 1'b1; a_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00A0); a_tlast = 1'b1;
    b_tvalid = 1'b1; b_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00B0); b_tlast = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (o_tdata[511:480] == 32'hA0) na++;
      if (o_tdata[511:480] == 32'hB0) nb++;
      tests_run++;
      if (o_tvalid !== 1'b1 || o_tdata[511:480] !== ((k % 2 == 0) ? 32'hA0 : 32'hB0)) begin
        fails++; $display("FAIL alt_order beat %0d got v=%b id=%h want v=1 id=%h", k, o_tvalid, o_tdata[511:480], (k % 2 == 0) ? 32'hA0 : 32'hB0);
      end
      if (k == 7) begin a_tvalid = 1'b0; b_tvalid = 1'b0; end
    end
    tests_run++; if (na != 4 || nb != 4) begin fails++; $display("FAIL alt_counts got a=%0d b=%0d want 4 4", na, nb); end
    @(negedge clk);
  endtask

  task automatic test_lock();
    do_reset();
    o_tready = 1'b1; c_tready = 1'b1;
    b_tvalid = 1'b1; b_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00B1); b_tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_tvalid = 1'b1; a_tlast = (i == 3);
      a_tdata = (i == 0) ? mk_hdr(8'h40, 10'h155, 32'hA0) : mk_hdr(8'h00, 10'h0, 32'hA0 + 32'(i));
      #1;
      tests_run++; if (a_tready !== 1'b1 || b_tready !== 1'b0) begin fails++; $display("FAIL lock_grant beat %0d got a=%b b=%b want 1 0", i, a_tready, b_tready); end
      if (i > 0) begin
        tests_run++; if (o_tdata[511:480] !== 32'hA0 + 32'(i - 1)) begin fails++; $display("FAIL lock_out beat %0d got id=%h want %h", i, o_tdata[511:480], 32'hA0 + 32'(i - 1)); end
      end
    end
    @(negedge clk);
    a_tvalid = 1'b0; a_tlast = 1'b0;
    #1;
    tests_run++; if (o_tdata[511:480] !== 32'hA3 || o_tlast !== 1'b1) begin fails++; $display("FAIL lock_last got id=%h last=%b want a3 1", o_tdata[511:480], o_tlast); end
    tests_run++; if (b_tready !== 1'b1) begin fails++; $display("FAIL lock_b_next got %b want 1", b_tready); end
    @(negedge clk);
    b_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tdata[511:480] !== 32'hB1) begin fails++; $display("FAIL lock_b_out got id=%h want b1", o_tdata[511:480]); end
    tests_run++; if (c_tvalid !== 1'b1 || c_tdata !== mk_hdr(8'h0A, 10'h155, 32'h0)) begin fails++; $display("FAIL lock_commit got v=%b d=%h want v=1 tag 155", c_tvalid, c_tdata); end
    @(negedge clk);
  endtask

  task automatic test_commit_full();
    do_reset();
    o_tready = 1'b1; c_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_tvalid = 1'b1; a_tlast = 1'b1; a_tdata = mk_hdr(8'h60, 10'(k), 32'h100 + 32'(k));
      #1;
      tests_run++; if (a_tready !== 1'b1) begin fails++; $display("FAIL full_accept write %0d got %b want 1", k, a_tready); end
    end
    @(negedge clk);
    a_tdata = mk_hdr(8'h60, 10'd8, 32'h108);
    b_tvalid = 1'b1; b_tlast = 1'b1; b_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00B2);
    #1;
    tests_run++; if (a_tready !== 1'b0 || b_tready !== 1'b1) begin fails++; $display("FAIL full_hold got a=%b b=%b want 0 1", a_tready, b_tready); end
    @(negedge clk);
    #1;
    tests_run++; if (a_tready !== 1'b0 || b_tready !== 1'b1) begin fails++; $display("FAIL full_hold2 got a=%b b=%b want 0 1", a_tready, b_tready); end
    @(negedge clk);
    b_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tdata[511:480] !== 32'hB2) begin fails++; $display("FAIL full_b_flow got id=%h want b2", o_tdata[511:480]); end
    tests_run++; if (c_tvalid !== 1'b1 || c_tdata !== mk_hdr(8'h0A, 10'd0, 32'h0)) begin fails++; $display("FAIL full_head got v=%b d=%h want tag 0", c_tvalid, c_tdata); end
    tests_run++; if (a_tready !== 1'b0) begin fails++; $display("FAIL full_still_held got %b want 0", a_tready); end
    c_tready = 1'b1;
    @(negedge clk);
    c_tready = 1'b0;
    #1;
    tests_run++; if (a_tready !== 1'b1) begin fails++; $display("FAIL full_release got %b want 1", a_tready); end
    @(negedge clk);
    a_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tvalid !== 1'b1 || o_tdata !== mk_hdr(8'h60, 10'd8, 32'h108)) begin fails++; $display("FAIL full_ninth got v=%b id=%h want v=1 id=108", o_tvalid, o_tdata[511:480]); end
    @(negedge clk);
    c_tready = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      tests_run++; if (c_tvalid !== 1'b1 || c_tdata !== mk_hdr(8'h0A, 10'(k), 32'h0)) begin fails++; $display("FAIL full_order entry %0d got v=%b d=%h want tag %0d", k, c_tvalid, c_tdata, k); end
      @(negedge clk);
      #1;
    end
    tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL full_empty got %b want 0", c_tvalid); end
    c_tready = 1'b0;
  endtask

  task automatic test_read_no_commit();
    logic [511:0] d;
    do_reset();
    o_tready = 1'b1; c_tready = 1'b1;
    d = mk_hdr(8'h20, 10'h033, 32'h0000_00D0);
    @(negedge clk);
    a_tvalid = 1'b1; a_tdata = d; a_tlast = 1'b1;
    #1;
    tests_run++; if (a_tready !== 1'b1) begin fails++; $display("FAIL rd_a_tready got %b want 1", a_tready); end
    @(negedge clk);
    a_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tvalid !== 1'b1 || o_tdata !== d) begin fails++; $display("FAIL rd_out got v=%b id=%h want v=1 id=d0", o_tvalid, o_tdata[511:480]); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL rd_no_commit cycle %0d got %b want 0", k, c_tvalid); end
    end
  endtask

  task automatic test_reset_mid(input bit b_only);
    do_reset();
    o_tready = 1'b1; c_tready = 1'b1;
    @(negedge clk);
    a_tvalid = 1'b1; a_tlast = 1'b1; a_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00C0);
    @(negedge clk);
    a_tlast = 1'b0; a_tdata = mk_hdr(8'h60, 10'h03C, 32'h0000_00C1);
    #1;
    tests_run++; if (a_tready !== 1'b1) begin fails++; $display("FAIL rstmid_sop got %b want 1", a_tready); end
    @(negedge clk);
    o_tready = 1'b0; a_tlast = 1'b1; a_tdata = mk_hdr(8'h00, 10'h0, 32'h0000_00C2);
    #1;
    tests_run++; if (a_tready !== 1'b0) begin fails++; $display("FAIL rstmid_stall got %b want 0", a_tready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (o_tvalid !== 1'b0 || c_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_clear got o=%b c=%b want 0 0", o_tvalid, c_tvalid); end
    o_tready = 1'b1;
    a_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00C3);
    b_tvalid = 1'b1; b_tlast = 1'b1; b_tdata = mk_hdr(8'h20, 10'h0, 32'h0000_00B3);
    a_tvalid = !b_only;
    #1;
    if (b_only) begin
      tests_run++; if (b_tready !== 1'b1) begin fails++; $display("FAIL rstmid_idle got b_tready=%b want 1", b_tready); end
    end else begin
      tests_run++; if (a_tready !== 1'b1 || b_tready !== 1'b0) begin fails++; $display("FAIL rstmid_rr got a=%b b=%b want 1 0", a_tready, b_tready); end
    end
    @(negedge clk);
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    #1;
    tests_run++; if (o_tdata[511:480] !== (b_only ? 32'hB3 : 32'hC3)) begin fails++; $display("FAIL rstmid_out got id=%h want %h", o_tdata[511:480], b_only ? 32'hB3 : 32'hC3); end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++; if (c_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_no_commit got %b want 0", c_tvalid); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_alternate();
    test_lock();
    test_commit_full();
    test_read_no_commit();
    test_reset_mid(1'b1);
    test_reset_mid(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
